actuator_reg_bank: RTL and testbench

//  Parametrised, double-buffered register bank for the actuator controller.

---
 rtl/act_reg_pkg.sv | 16 +
 rtl/act_ccr_channel.sv | 28 ++
 rtl/actuator_reg_bank.sv | 133 +++++++++++++
 tb/tb_actuator_reg_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_reg_pkg.sv
// Shared address map and CTRL/STAT bit positions for the actuator register bank.
package act_reg_pkg;

  localparam int unsigned ADDR_CELL     = 0;
  localparam int unsigned ADDR_CTRL     = 1;
  localparam int unsigned ADDR_STAT     = 2;
  localparam int unsigned ADDR_CCR_BASE = 4;

  localparam int unsigned CTRL_AUTO     = 0;
  localparam int unsigned CTRL_COMMIT   = 1;
  localparam int unsigned CTRL_LOCK     = 2;

  localparam int unsigned STAT_PENDING  = 0;
  localparam int unsigned STAT_ERR      = 1;

endpackage

// File: rtl/act_ccr_channel.sv
// One actuator channel: WPC shadow words plus the live CCR they commit into.
module act_ccr_channel #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WPC    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WPC-1:0]        word_we,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  commit,
  output logic [WPC*DATA_W-1:0] shadow,
  output logic [WPC*DATA_W-1:0] live
);

  // Commit samples the shadow before any same-edge word write lands.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      live   <= '0;
    end else begin
      if (commit) live <= shadow;
      for (int unsigned k = 0; k < WPC; k++) begin
        if (word_we[k]) shadow[k*DATA_W +: DATA_W] <= wdata;
      end
    end
  end

endmodule

// File: rtl/actuator_reg_bank.sv
// Double-buffered actuator CCR bank: bus decode, CTRL/STAT, read mux and commit.
// Optional shadow write lock is built when ACT_REG_LOCK_EN is defined.
module actuator_reg_bank
  import act_reg_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CCR_W  = 32,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    memory_enable_n,
  input  logic                    memory_write_n,
  input  logic                    memory_read_n,
  input  logic [ADDR_W-1:0]       memory_address,
  input  logic [DATA_W-1:0]       memory_data_in,
  output logic [DATA_W-1:0]       memory_data_out,
  output logic                    memory_rvalid,
  input  logic                    period_end,
  output logic [DATA_W-1:0]       cell_state,
  output logic [NUM_CH*CCR_W-1:0] ccr_live,
  output logic                    commit_pulse
);

  localparam int unsigned WPC       = CCR_W / DATA_W;
  localparam int unsigned NUM_WORDS = NUM_CH * WPC;

  logic              bus_wr, bus_rd;
  logic              hit_cell, hit_ctrl, hit_stat, hit_ccr, mapped;
  logic [ADDR_W-1:0] ccr_off;
  logic [31:0]       ccr_idx;
  logic              shadow_wr_req, shadow_wr, lock_drop, lock_on;
  logic              trigger, err_set, err_clr;
  logic              auto_q, pending_q, err_q;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_CH*CCR_W-1:0] shadow_all;

  assign bus_wr   = ~memory_enable_n & ~memory_write_n;
  assign bus_rd   = ~memory_enable_n & ~memory_read_n;

  assign hit_cell = (memory_address == ADDR_W'(ADDR_CELL));
  assign hit_ctrl = (memory_address == ADDR_W'(ADDR_CTRL));
  assign hit_stat = (memory_address == ADDR_W'(ADDR_STAT));
  assign ccr_off  = memory_address - ADDR_W'(ADDR_CCR_BASE);
  assign ccr_idx  = 32'(ccr_off);
  assign hit_ccr  = (memory_address >= ADDR_W'(ADDR_CCR_BASE)) && (ccr_idx < NUM_WORDS);
  assign mapped   = hit_cell | hit_ctrl | hit_stat | hit_ccr;

`ifdef ACT_REG_LOCK_EN
  logic lock_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                lock_q <= 1'b0;
    else if (bus_wr && hit_ctrl) lock_q <= memory_data_in[CTRL_LOCK];
  end

  assign lock_on = lock_q;
`else
  assign lock_on = 1'b0;
`endif

  assign shadow_wr_req = bus_wr & hit_ccr;
  assign shadow_wr     = shadow_wr_req & ~lock_on;
  assign lock_drop     = shadow_wr_req & lock_on;

  assign trigger = (bus_wr & hit_ctrl & memory_data_in[CTRL_COMMIT]) | (period_end & auto_q);
  assign err_set = ((bus_wr | bus_rd) & ~mapped) | lock_drop;
  assign err_clr = bus_wr & hit_stat & memory_data_in[STAT_ERR];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WPC-1:0] word_we;

    for (genvar k = 0; k < WPC; k++) begin : g_we
      assign word_we[k] = shadow_wr && (ccr_idx == 32'(ch*WPC + k));
    end

    act_ccr_channel #(
      .DATA_W (DATA_W),
      .WPC    (WPC)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .word_we (word_we),
      .wdata   (memory_data_in),
      .commit  (trigger),
      .shadow  (shadow_all[ch*CCR_W +: CCR_W]),
      .live    (ccr_live[ch*CCR_W +: CCR_W])
    );
  end

  // Read mux sees pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    rd_data = '0;
    if (hit_cell) begin
      rd_data = cell_state;
    end else if (hit_ctrl) begin
      rd_data[CTRL_AUTO] = auto_q;
      rd_data[CTRL_LOCK] = lock_on;
    end else if (hit_stat) begin
      rd_data[STAT_PENDING] = pending_q;
      rd_data[STAT_ERR]     = err_q;
    end else if (hit_ccr) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        if (ccr_idx == i) rd_data = shadow_all[i*DATA_W +: DATA_W];
      end
    end
  end

  // A shadow write coincident with a commit leaves PENDING set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cell_state      <= '0;
      auto_q          <= 1'b0;
      pending_q       <= 1'b0;
      err_q           <= 1'b0;
      commit_pulse    <= 1'b0;
      memory_rvalid   <= 1'b0;
      memory_data_out <= '0;
    end else begin
      commit_pulse  <= trigger;
      memory_rvalid <= bus_rd;
      if (bus_rd)              memory_data_out <= rd_data;
      if (bus_wr && hit_cell)  cell_state      <= memory_data_in;
      if (bus_wr && hit_ctrl)  auto_q          <= memory_data_in[CTRL_AUTO];
      if (shadow_wr)           pending_q       <= 1'b1;
      else if (trigger)        pending_q       <= 1'b0;
      if (err_set)             err_q           <= 1'b1;
      else if (err_clr)        err_q           <= 1'b0;
    end
  end

endmodule

// File: tb/tb_actuator_reg_bank.sv
// Directed plus randomized bench for actuator_reg_bank against an array-based register model.
module tb_actuator_reg_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CCR_W  = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WPC    = CCR_W / DATA_W;
  localparam int unsigned NW     = NUM_CH * WPC;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    memory_enable_n = 1'b1;
  logic                    memory_write_n = 1'b1;
  logic                    memory_read_n = 1'b1;
  logic [ADDR_W-1:0]       memory_address = '0;
  logic [DATA_W-1:0]       memory_data_in = '0;
  logic [DATA_W-1:0]       memory_data_out;
  logic                    memory_rvalid;
  logic                    period_end = 1'b0;
  logic [DATA_W-1:0]       cell_state;
  logic [NUM_CH*CCR_W-1:0] ccr_live;
  logic                    commit_pulse;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_shadow [NW];
  logic [15:0] m_live   [NW];
  logic [15:0] m_cell, m_dout;
  bit          m_auto, m_lock, m_pend, m_err, m_cp, m_rv;

  actuator_reg_bank #(
    .NUM_CH (NUM_CH),
    .CCR_W  (CCR_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .memory_enable_n (memory_enable_n),
    .memory_write_n  (memory_write_n),
    .memory_read_n   (memory_read_n),
    .memory_address  (memory_address),
    .memory_data_in  (memory_data_in),
    .memory_data_out (memory_data_out),
    .memory_rvalid   (memory_rvalid),
    .period_end      (period_end),
    .cell_state      (cell_state),
    .ccr_live        (ccr_live),
    .commit_pulse    (commit_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) begin
      m_shadow[i] = '0;
      m_live[i]   = '0;
    end
    m_cell = '0; m_dout = '0;
    m_auto = 0; m_lock = 0; m_pend = 0; m_err = 0; m_cp = 0; m_rv = 0;
  endtask

  function automatic logic [NUM_CH*CCR_W-1:0] live_flat();
    logic [NUM_CH*CCR_W-1:0] v;
    v = '0;
    for (int i = 0; i < NW; i++) v[i*DATA_W +: DATA_W] = m_live[i];
    return v;
  endfunction

  function automatic logic [15:0] model_read(input int a);
    if (a == 0) return m_cell;
    if (a == 1) return 16'(m_auto) | (16'(m_lock) << 2);
    if (a == 2) return 16'(m_pend) | (16'(m_err) << 1);
    if (a >= 4 && a < 4 + NW) return m_shadow[a-4];
    return 16'h0000;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":ccr_live"}, 128'(ccr_live), 128'(live_flat()));
    chk({tag, ":cell"},     128'(cell_state), 128'(m_cell));
    chk({tag, ":cpulse"},   128'(commit_pulse), 128'(m_cp));
    chk({tag, ":rvalid"},   128'(memory_rvalid), 128'(m_rv));
    chk({tag, ":dout"},     128'(memory_data_out), 128'(m_dout));
  endtask

  // One bus cycle: drive, advance one edge, update the model, compare.
  task automatic step(input bit wr, input bit rd, input int a, input logic [15:0] d, input bit pe);
    bit mapped, ccr, trig;
    memory_enable_n = !(wr || rd);
    memory_write_n  = !wr;
    memory_read_n   = !rd;
    memory_address  = 8'(a);
    memory_data_in  = d;
    period_end      = pe;
    @(posedge clock);
    ccr    = (a >= 4) && (a < 4 + NW);
    mapped = (a <= 2) || ccr;
    m_rv   = rd;
    if (rd) m_dout = model_read(a);
    trig = (wr && a == 1 && d[1]) || (pe && m_auto);
    m_cp = trig;
    if (trig) begin
      for (int i = 0; i < NW; i++) m_live[i] = m_shadow[i];
      m_pend = 0;
    end
    if ((wr || rd) && !mapped) m_err = 1;
    if (wr) begin
      if (a == 0) m_cell = d;
      else if (a == 1) begin
        m_auto = d[0];
`ifdef ACT_REG_LOCK_EN
        m_lock = d[2];
`endif
      end else if (a == 2) begin
        if (d[1]) m_err = 0;
      end else if (ccr) begin
        if (m_lock) m_err = 1;
        else begin
          m_shadow[a-4] = d;
          m_pend = 1;
        end
      end
    end
    #1;
    check_all("step");
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    int a;
    bit wr, rd, pe;
    logic [15:0] d;

    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_all("reset");

    // Shadow writes stay invisible until a software commit.
    step(1, 0, 4, 16'hBEEF, 0);
    step(1, 0, 5, 16'h1234, 0);
    chk("t2_live_before", 128'(ccr_live[31:0]), 128'h0);
    step(0, 1, 2, 16'h0, 0);
    chk("t2_pending_set", 128'(memory_data_out[0]), 128'h1);
    step(1, 0, 1, 16'h0002, 0);
    chk("t2_live_after", 128'(ccr_live[31:0]), 128'h1234BEEF);
    chk("t2_commit_pulse", 128'(commit_pulse), 128'h1);
    idle();
    chk("t2_pulse_once", 128'(commit_pulse), 128'h0);
    step(0, 1, 2, 16'h0, 0);
    chk("t2_pending_clr", 128'(memory_data_out[0]), 128'h0);
    step(0, 1, 1, 16'h0, 0);
    chk("t2_commit_reads0", 128'(memory_data_out), 128'h0);

    // Auto commit on period boundary.
    step(1, 0, 1, 16'h0001, 0);
    step(1, 0, 6, 16'hCAFE, 0);
    step(1, 0, 7, 16'hF00D, 0);
    chk("t3_live_hold", 128'(ccr_live[63:32]), 128'h0);
    step(0, 0, 0, 16'h0, 1);
    chk("t3_live_auto", 128'(ccr_live[63:32]), 128'hF00DCAFE);

    // Shadow write coincident with auto commit.
    step(1, 0, 4, 16'hAAAA, 1);
    chk("t4_live_old", 128'(ccr_live[15:0]), 128'hBEEF);
    step(0, 1, 4, 16'h0, 0);
    chk("t4_shadow_new", 128'(memory_data_out), 128'hAAAA);
    step(0, 1, 2, 16'h0, 0);
    chk("t4_pending", 128'(memory_data_out[0]), 128'h1);

    // Read and write the same register in one cycle returns the old value.
    step(1, 1, 0, 16'h7777, 0);
    chk("rw_old_value", 128'(memory_data_out), 128'h0);
    chk("rw_cell_new", 128'(cell_state), 128'h7777);

    // Unmapped access and write-1-to-clear.
    step(0, 1, 255, 16'h0, 0);
    chk("t5_dout0", 128'(memory_data_out), 128'h0);
    chk("t5_rvalid", 128'(memory_rvalid), 128'h1);
    step(0, 1, 2, 16'h0, 0);
    chk("t5_err_set", 128'(memory_data_out[1]), 128'h1);
    step(1, 0, 2, 16'h0002, 0);
    step(0, 1, 2, 16'h0, 0);
    chk("t5_err_clr", 128'(memory_data_out[1]), 128'h0);
    step(1, 0, 3, 16'h1111, 0);
    step(0, 1, 2, 16'h0, 0);
    chk("t5_err_wr3", 128'(memory_data_out[1]), 128'h1);
    step(1, 0, 2, 16'h0002, 0);

`ifdef ACT_REG_LOCK_EN
    step(1, 0, 1, 16'h0004, 0);
    step(1, 0, 4, 16'h5555, 0);
    step(0, 1, 4, 16'h0, 0);
    chk("t6_shadow_kept", 128'(memory_data_out), 128'hAAAA);
    step(0, 1, 2, 16'h0, 0);
    chk("t6_err_lock", 128'(memory_data_out[1]), 128'h1);
    step(1, 0, 0, 16'h4242, 0);
    chk("t6_cell_wr", 128'(cell_state), 128'h4242);
    step(1, 0, 1, 16'h0000, 0);
    step(1, 0, 2, 16'h0002, 0);
`endif

    // Randomized traffic against the model, with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      pe = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 4 + NW + 1));
      d  = 16'($urandom);
      if (a == 1 && $urandom_range(0, 1) == 0) d[2] = 1'b0;
      step(wr, rd, a, d, pe);
      if (n == 200) begin
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
      end
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
